// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package div_pkg;

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  // Widest operand the abs helper can carry.
  localparam int unsigned MaxW    = 64;
  localparam int unsigned MaxIdxW = $clog2(MaxW);

  // Iteration counter width; at least one bit even for a single-cycle divide.
  function automatic int unsigned cnt_width(input int unsigned w, input int unsigned bpc);
    int unsigned n;
    n = w / bpc;
    if (n > 1) return unsigned'($clog2(n));
    return 1;
  endfunction

  // Magnitude of a w-bit two's-complement value when en is set; caller truncates to w bits.
  function automatic logic [MaxW-1:0] abs_w(input logic [MaxW-1:0] val, input logic en,
                                            input int unsigned w);
    logic neg;
    neg = en & val[MaxIdxW'(w - 1)];
    return neg ? -val : val;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake, operands and results of the sequential divider.
interface seq_divider_if #(
  parameter int unsigned W = 8
);
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  ready, busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output ready, busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
module div_step #(
  parameter int unsigned W = 8
) (
  input  logic [W:0]   pr_i,
  input  logic         dbit_i,
  input  logic [W-1:0] divisor_i,
  output logic [W:0]   pr_next_o,
  output logic         qbit_o
);

  logic [W+1:0] diff;

  always_comb begin
    diff      = {pr_i, dbit_i} - {2'b00, divisor_i};
    qbit_o    = ~diff[W+1];
    pr_next_o = qbit_o ? diff[W:0] : {pr_i[W-1:0], dbit_i};
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider retiring BPC quotient bits per clock, with signed mode
// and divide-by-zero detection.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned W   = 8,
  parameter int unsigned BPC = 2
) (
  input  logic         clk,
  input  logic         reset,
  seq_divider_if.slave bus
);

  localparam int unsigned N    = W / BPC;
  localparam int unsigned CntW = cnt_width(W, BPC);
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  if ((W < 2) || (W > MaxW) || (W % BPC != 0) || !((BPC == 1) || (BPC == 2) || (BPC == 4)))
  begin : g_param_err
    $error("seq_divider: illegal W=%0d / BPC=%0d combination", W, BPC);
  end

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    dvd_q, dvd_d;
  logic [W-1:0]    dvs_q, dvs_d;
  logic [W:0]      pr_q, pr_d;
  logic            qsign_q, qsign_d;
  logic            rsign_q, rsign_d;
  logic            zero_q, zero_d;
  logic [W-1:0]    quot_q, quot_d;
  logic [W-1:0]    rem_q, rem_d;
  logic            dbz_q, dbz_d;
  logic            done_q, done_d;

  logic [BPC:0][W:0] pr_chain;
  logic [BPC-1:0]    qbits;

  // dvd_q doubles as the quotient shift register: dividend MSBs leave, quotient bits enter.
  assign pr_chain[0] = pr_q;
  for (genvar i = 0; i < BPC; i++) begin : g_step
    div_step #(
      .W (W)
    ) u_step (
      .pr_i      (pr_chain[i]),
      .dbit_i    (dvd_q[W-1-i]),
      .divisor_i (dvs_q),
      .pr_next_o (pr_chain[i+1]),
      .qbit_o    (qbits[BPC-1-i])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    pr_d    = pr_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    zero_d  = zero_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          pr_d  = '0;
          cnt_d = '0;
          if (bus.divisor == '0) begin
            zero_d  = 1'b1;
            dvd_d   = bus.dividend;
            qsign_d = 1'b0;
            rsign_d = 1'b0;
            state_d = StFix;
          end else begin
            zero_d  = 1'b0;
            dvd_d   = W'(abs_w(MaxW'(bus.dividend), bus.is_signed, W));
            dvs_d   = W'(abs_w(MaxW'(bus.divisor), bus.is_signed, W));
            qsign_d = bus.is_signed & (bus.dividend[W-1] ^ bus.divisor[W-1]);
            rsign_d = bus.is_signed & bus.dividend[W-1];
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        pr_d  = pr_chain[BPC];
        dvd_d = (dvd_q << BPC) | W'(qbits);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) state_d = StFix;
      end
      StFix: begin
        done_d = 1'b1;
        dbz_d  = zero_q;
        if (zero_q) begin
          quot_d = '1;
          rem_d  = dvd_q;
        end else begin
          quot_d = qsign_q ? -dvd_q : dvd_q;
          rem_d  = rsign_q ? -pr_q[W-1:0] : pr_q[W-1:0];
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      pr_q    <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      zero_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      pr_q    <= pr_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      zero_q  <= zero_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready       = (state_q == StIdle);
  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider against an arithmetic reference model.
module tb_seq_divider;

  localparam int unsigned NOps = 400;

  logic clk = 1'b0;
  logic rst_dir;
  logic rst_sweep;
  logic sweep_go = 1'b0;
  int   sweep_fin = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Division by the language's own integer operators; signed truncates toward zero.
  task automatic ref_div(input int unsigned w, input logic sg, input logic [63:0] a,
                         input logic [63:0] b, output logic [63:0] q, output logic [63:0] r,
                         output logic z);
    logic [63:0] mask;
    longint      sa, sb;
    mask = (64'd1 << w) - 64'd1;
    if (b == 64'd0) begin
      q = mask;
      r = a;
      z = 1'b1;
    end else begin
      z = 1'b0;
      if (sg) begin
        sa = longint'(a << (64 - w)) >>> (64 - w);
        sb = longint'(b << (64 - w)) >>> (64 - w);
        q  = 64'(sa / sb) & mask;
        r  = 64'(sa % sb) & mask;
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endtask

  // ---------------- directed instance, W=8 BPC=2 ----------------
  seq_divider_if #(.W(8)) dif ();
  seq_divider #(
    .W   (8),
    .BPC (2)
  ) u_dut (
    .clk   (clk),
    .reset (rst_dir),
    .bus   (dif)
  );

  // Caller is at a negedge; start is sampled at the next posedge (edge 0).
  task automatic issue(input logic sg, input logic [7:0] a, input logic [7:0] b);
    dif.start     = 1'b1;
    dif.is_signed = sg;
    dif.dividend  = a;
    dif.divisor   = b;
    @(posedge clk);
    #1;
    dif.start     = 1'b0;
    dif.is_signed = 1'($urandom_range(0, 1));
    dif.dividend  = 8'($urandom);
    dif.divisor   = 8'($urandom);
  endtask

  // Returns at the negedge where done is high; lat = edges after the start edge.
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    @(negedge clk);
    while (!dif.done && lat < 40) begin
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic exp_res(input string t, input int lat, input int elat, input logic [7:0] q,
                         input logic [7:0] r, input logic z);
    check({t, "_lat"}, 64'(lat), 64'(elat));
    check({t, "_q"}, 64'(dif.quotient), 64'(q));
    check({t, "_r"}, 64'(dif.remainder), 64'(r));
    check({t, "_dbz"}, 64'(dif.div_by_zero), 64'(z));
  endtask

  initial begin
    int lat;
    int ndone;
    dif.start     = 1'b0;
    dif.is_signed = 1'b0;
    dif.dividend  = '0;
    dif.divisor   = '0;
    rst_dir       = 1'b1;
    rst_sweep     = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(dif.ready), 64'd1);
    check("rst_busy", 64'(dif.busy), 64'd0);
    check("rst_done", 64'(dif.done), 64'd0);
    check("rst_q", 64'(dif.quotient), 64'd0);
    check("rst_r", 64'(dif.remainder), 64'd0);
    check("rst_dbz", 64'(dif.div_by_zero), 64'd0);
    rst_dir   = 1'b0;
    rst_sweep = 1'b0;
    sweep_go  = 1'b1;

    @(negedge clk); issue(1'b0, 8'd100, 8'd7); wait_done(0, lat);
    exp_res("u100_7", lat, 5, 8'd14, 8'd2, 1'b0);
    @(negedge clk);
    check("u100_7_pulse", 64'(dif.done), 64'd0);
    check("u100_7_hold", 64'(dif.quotient), 64'd14);

    @(negedge clk); issue(1'b1, 8'hF9, 8'h02); wait_done(0, lat);
    exp_res("sm7_2", lat, 5, 8'hFD, 8'hFF, 1'b0);
    @(negedge clk); issue(1'b1, 8'h07, 8'hFE); wait_done(0, lat);
    exp_res("s7_m2", lat, 5, 8'hFD, 8'h01, 1'b0);

    @(negedge clk); issue(1'b0, 8'd55, 8'd0); wait_done(0, lat);
    exp_res("u55_0", lat, 1, 8'hFF, 8'd55, 1'b1);
    @(negedge clk); issue(1'b1, 8'd55, 8'd0); wait_done(0, lat);
    exp_res("s55_0", lat, 1, 8'hFF, 8'd55, 1'b1);
    @(negedge clk); issue(1'b0, 8'd9, 8'd3); wait_done(0, lat);
    exp_res("u9_3", lat, 5, 8'd3, 8'd0, 1'b0);

    @(negedge clk); issue(1'b1, 8'h80, 8'hFF); wait_done(0, lat);
    exp_res("smin_m1", lat, 5, 8'h80, 8'h00, 1'b0);
    @(negedge clk); issue(1'b0, 8'hFF, 8'h01); wait_done(0, lat);
    exp_res("uff_1", lat, 5, 8'hFF, 8'h00, 1'b0);

    // start while busy must be ignored
    @(negedge clk); issue(1'b0, 8'd200, 8'd9);
    @(negedge clk);
    @(negedge clk);
    check("busy_mid", 64'(dif.busy), 64'd1);
    check("ready_mid", 64'(dif.ready), 64'd0);
    dif.start     = 1'b1;
    dif.is_signed = 1'b1;
    dif.dividend  = 8'd5;
    dif.divisor   = 8'd5;
    @(posedge clk);
    #1 dif.start = 1'b0;
    wait_done(2, lat);
    exp_res("busy_ign", lat, 5, 8'd22, 8'd2, 1'b0);
    // back-to-back start on the done cycle
    issue(1'b0, 8'd50, 8'd6); wait_done(0, lat);
    exp_res("b2b", lat, 5, 8'd8, 8'd2, 1'b0);

    // reset two cycles into CALC after a divide-by-zero result
    @(negedge clk); issue(1'b0, 8'd55, 8'd0); wait_done(0, lat);
    check("pre_rst_dbz", 64'(dif.div_by_zero), 64'd1);
    @(negedge clk); issue(1'b0, 8'd100, 8'd7);
    @(negedge clk);
    @(negedge clk);
    rst_dir = 1'b1;
    #1;
    check("mrst_ready", 64'(dif.ready), 64'd1);
    check("mrst_busy", 64'(dif.busy), 64'd0);
    check("mrst_done", 64'(dif.done), 64'd0);
    check("mrst_q", 64'(dif.quotient), 64'd0);
    check("mrst_r", 64'(dif.remainder), 64'd0);
    check("mrst_dbz", 64'(dif.div_by_zero), 64'd0);
    @(negedge clk);
    rst_dir = 1'b0;
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (dif.done) ndone++;
    end
    check("mrst_no_done", 64'(ndone), 64'd0);

    for (int c = 0; c < 40000 && sweep_fin < 4; c++) @(negedge clk);
    check("sweep_fin", 64'(sweep_fin), 64'd4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // ---------------- randomized sweep: (8,2) (16,1) (16,2) (16,4) ----------------
  for (genvar k = 0; k < 4; k++) begin : g_sweep
    localparam int unsigned SW = (k == 0) ? 8 : 16;
    localparam int unsigned SB = (k == 0) ? 2 : (1 << (k - 1));

    seq_divider_if #(.W(SW)) sif ();
    seq_divider #(
      .W   (SW),
      .BPC (SB)
    ) u_dut (
      .clk   (clk),
      .reset (rst_sweep),
      .bus   (sif)
    );

    logic [SW-1:0] a, b;
    logic          sg;
    logic [63:0]   eq, er;
    logic          ez;
    int            lat;
    int            sel;

    initial begin
      sif.start     = 1'b0;
      sif.is_signed = 1'b0;
      sif.dividend  = '0;
      sif.divisor   = '0;
      wait (sweep_go);
      for (int n = 0; n < NOps; n++) begin
        sel = int'($urandom_range(0, 15));
        a   = SW'($urandom);
        b   = SW'($urandom);
        sg  = 1'($urandom_range(0, 1));
        if (sel == 0) b = '0;
        else if (sel == 1) begin
          a = {1'b1, {(SW - 1) {1'b0}}};
          b = '1;
        end else if (sel < 6) b = SW'($urandom_range(1, 7));
        ref_div(SW, sg, 64'(a), 64'(b), eq, er, ez);
        @(negedge clk);
        sif.start     = 1'b1;
        sif.is_signed = sg;
        sif.dividend  = a;
        sif.divisor   = b;
        @(posedge clk);
        #1;
        sif.start     = 1'b0;
        sif.is_signed = 1'($urandom_range(0, 1));
        sif.dividend  = SW'($urandom);
        sif.divisor   = SW'($urandom);
        lat = 0;
        @(negedge clk);
        while (!sif.done && lat < 40) begin
          lat++;
          @(negedge clk);
        end
        check($sformatf("w%0d_b%0d_lat", SW, SB), 64'(lat), ez ? 64'd1 : 64'(SW / SB + 1));
        check($sformatf("w%0d_b%0d_q", SW, SB), 64'(sif.quotient), eq);
        check($sformatf("w%0d_b%0d_r", SW, SB), 64'(sif.remainder), er);
        check($sformatf("w%0d_b%0d_dbz", SW, SB), 64'(sif.div_by_zero), 64'(ez));
      end
      sweep_fin++;
    end
  end

endmodule
